// File: rtl/cu_pkg.sv
// Shared encodings and the control bundle carried through the pipeline.
package cu_pkg;

  // Storage widths of the control bundle fields.
  localparam int unsigned CU_RA_W    = 5;
  localparam int unsigned CU_ALUOP_W = 3;

  // Opcodes.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes.
  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_OR  = 6'd3;
  localparam logic [5:0] FN_SLT = 6'd4;

  // ALU operation encodings; all-ones marks "no ALU operation".
  localparam logic [CU_ALUOP_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [CU_ALUOP_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [CU_ALUOP_W-1:0] ALU_AND  = 3'b010;
  localparam logic [CU_ALUOP_W-1:0] ALU_OR   = 3'b011;
  localparam logic [CU_ALUOP_W-1:0] ALU_SLT  = 3'b100;
  localparam logic [CU_ALUOP_W-1:0] ALU_NONE = 3'b111;

  // Next-PC source selection.
  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2
  } pcsrc_e;

  typedef struct packed {
    logic [CU_ALUOP_W-1:0] alu_op;
    logic                  alu_src;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  link;
    logic                  nop;
    logic [CU_RA_W-1:0]    wreg;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '{
    alu_op:     ALU_NONE,
    alu_src:    1'b0,
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    link:       1'b0,
    nop:        1'b1,
    wreg:       '0
  };

endpackage

// File: rtl/cu_decode.sv
// Combinational ID-stage decoder: instruction fields to a control bundle
// plus the branch/jump/operand-use flags the hazard logic needs.
module cu_decode
  import cu_pkg::*;
#(
  parameter bit EN_IMM = 1'b1,
  parameter bit EN_JAL = 1'b1
) (
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic [CU_RA_W-1:0] rt,
  input  logic [CU_RA_W-1:0] rd,
  output ctrl_t              ctrl,
  output logic               is_beq,
  output logic               is_bne,
  output logic               is_j,
  output logic               reads_rt
);

  // Decode opcode/func; unknown or disabled opcodes fall through as a bubble.
  always_comb begin
    ctrl     = BUBBLE;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_j     = 1'b0;
    reads_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.nop       = 1'b0;
        ctrl.wreg      = rd;
        ctrl.reg_write = 1'b1;
        reads_rt       = 1'b1;
        case (func)
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          default: begin
            ctrl.alu_op    = ALU_NONE;
            ctrl.reg_write = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        ctrl.nop        = 1'b0;
        ctrl.alu_op     = ALU_ADD;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.wreg       = rt;
      end
      OP_SW: begin
        ctrl.nop       = 1'b0;
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        reads_rt       = 1'b1;
      end
      OP_BEQ: begin
        ctrl.nop = 1'b0;
        is_beq   = 1'b1;
        reads_rt = 1'b1;
      end
      OP_BNE: begin
        ctrl.nop = 1'b0;
        is_bne   = 1'b1;
        reads_rt = 1'b1;
      end
      OP_J: begin
        ctrl.nop = 1'b0;
        is_j     = 1'b1;
      end
      OP_JAL: begin
        if (EN_JAL) begin
          ctrl.nop       = 1'b0;
          ctrl.link      = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.wreg      = '1;
          is_j           = 1'b1;
        end
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        if (EN_IMM) begin
          ctrl.nop       = 1'b0;
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.wreg      = rt;
          case (opcode)
            OP_ANDI: ctrl.alu_op = ALU_AND;
            OP_ORI:  ctrl.alu_op = ALU_OR;
            OP_SLTI: ctrl.alu_op = ALU_SLT;
            default: ctrl.alu_op = ALU_ADD;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cu_pipe.sv
// Pipelined control unit: ID decode, hazard stall/flush, ID/EX..MEM/WB
// control registers and saturating stall/flush counters.
module cu_pipe
  import cu_pkg::*;
#(
  parameter int unsigned RA_W    = 5,
  parameter int unsigned ALUOP_W = 3,
  parameter bit          EN_IMM  = 1'b1,
  parameter bit          EN_JAL  = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic [RA_W-1:0]    rs,
  input  logic [RA_W-1:0]    rt,
  input  logic [RA_W-1:0]    rd,
  input  logic               equal,
  input  logic               notEqual,
  output logic               stall,
  output logic               flush_ifid,
  output logic [1:0]         PCsrc,
  output logic [ALUOP_W-1:0] ex_ALUop,
  output logic               ex_ALUsrc,
  output logic               ex_link,
  output logic [RA_W-1:0]    ex_wreg,
  output logic               ex_regWrite,
  output logic               ex_memRead,
  output logic               ex_memWrite,
  output logic [RA_W-1:0]    mem_wreg,
  output logic               mem_regWrite,
  output logic               mem_memRead,
  output logic               mem_memWrite,
  output logic               mem_memToReg,
  output logic [RA_W-1:0]    wb_wreg,
  output logic               wb_regWrite,
  output logic               wb_memToReg,
  output logic               wb_nop,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  ctrl_t              dec;
  ctrl_t              id_ex_d, id_ex_q, ex_mem_q, mem_wb_q;
  logic               is_beq, is_bne, is_j, reads_rt;
  logic               load_use, br_haz;
  logic               stall_w, flush_w;
  pcsrc_e             pc_sel;
  logic [CU_RA_W-1:0] rs_w, rt_w, rd_w;
  logic [CNT_W-1:0]   stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;
  logic               unused_wb_bits;

  assign rs_w = CU_RA_W'(rs);
  assign rt_w = CU_RA_W'(rt);
  assign rd_w = CU_RA_W'(rd);

  cu_decode #(
    .EN_IMM (EN_IMM),
    .EN_JAL (EN_JAL)
  ) u_decode (
    .opcode   (opcode),
    .func     (func),
    .rt       (rt_w),
    .rd       (rd_w),
    .ctrl     (dec),
    .is_beq   (is_beq),
    .is_bne   (is_bne),
    .is_j     (is_j),
    .reads_rt (reads_rt)
  );

  // Hazard detection against the instructions in EX and MEM; register 0 never matches.
  always_comb begin
    load_use = 1'b0;
    br_haz   = 1'b0;
    if (id_ex_q.mem_read && (id_ex_q.wreg != '0)) begin
      load_use = (id_ex_q.wreg == rs_w) || (reads_rt && (id_ex_q.wreg == rt_w));
    end
    if (is_beq || is_bne) begin
      if (id_ex_q.reg_write && (id_ex_q.wreg != '0) &&
          ((id_ex_q.wreg == rs_w) || (id_ex_q.wreg == rt_w))) begin
        br_haz = 1'b1;
      end
      if (ex_mem_q.mem_read && (ex_mem_q.wreg != '0) &&
          ((ex_mem_q.wreg == rs_w) || (ex_mem_q.wreg == rt_w))) begin
        br_haz = 1'b1;
      end
    end
  end

  // Stall/flush/PC selection; a hazard suppresses branch and jump resolution.
  always_comb begin
    stall_w = 1'b0;
    flush_w = 1'b0;
    pc_sel  = PC_SEQ;
    id_ex_d = dec;
    if (!rst) begin
      if (load_use || br_haz) begin
        stall_w = 1'b1;
        id_ex_d = BUBBLE;
      end else if ((is_beq && equal) || (is_bne && notEqual)) begin
        pc_sel  = PC_BRANCH;
        flush_w = 1'b1;
      end else if (is_j) begin
        pc_sel  = PC_JUMP;
        flush_w = 1'b1;
      end
    end
  end

  // Saturating next values of the performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_w && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_w && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Stage registers and counters; reset fills every stage with a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q     <= BUBBLE;
      ex_mem_q    <= BUBBLE;
      mem_wb_q    <= BUBBLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      id_ex_q     <= id_ex_d;
      ex_mem_q    <= id_ex_q;
      mem_wb_q    <= ex_mem_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall      = stall_w;
  assign flush_ifid = flush_w;
  assign PCsrc      = pc_sel;

  // The stored opcode is narrower than the port when ALUOP_W > 3; keep "none" all-ones.
  assign ex_ALUop    = (id_ex_q.alu_op == ALU_NONE) ? '1 : ALUOP_W'(id_ex_q.alu_op);
  assign ex_ALUsrc   = id_ex_q.alu_src;
  assign ex_link     = id_ex_q.link;
  assign ex_wreg     = RA_W'(id_ex_q.wreg);
  assign ex_regWrite = id_ex_q.reg_write;
  assign ex_memRead  = id_ex_q.mem_read;
  assign ex_memWrite = id_ex_q.mem_write;

  assign mem_wreg     = RA_W'(ex_mem_q.wreg);
  assign mem_regWrite = ex_mem_q.reg_write;
  assign mem_memRead  = ex_mem_q.mem_read;
  assign mem_memWrite = ex_mem_q.mem_write;
  assign mem_memToReg = ex_mem_q.mem_to_reg;

  assign wb_wreg     = RA_W'(mem_wb_q.wreg);
  assign wb_regWrite = mem_wb_q.reg_write;
  assign wb_memToReg = mem_wb_q.mem_to_reg;
  assign wb_nop      = mem_wb_q.nop;

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // WB has no consumer for the ALU/memory-access fields.
  assign unused_wb_bits = ^{mem_wb_q.alu_op, mem_wb_q.alu_src, mem_wb_q.mem_read,
                            mem_wb_q.mem_write, mem_wb_q.link};

endmodule

// File: tb/tb_cu_pipe.sv
// Directed bench for cu_pipe: default build (a_), EN_JAL=0 build (b_), CNT_W=2 build (c_).
module tb_cu_pipe;

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_J     = 6'b000010;
  localparam logic [5:0] T_JAL   = 6'b000011;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_BNE   = 6'b000101;
  localparam logic [5:0] T_ORI   = 6'b001101;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
  localparam logic [5:0] T_NOP   = 6'b111111;

  logic clk, rst;
  logic [5:0] opcode, func;
  logic [4:0] rs, rt, rd;
  logic equal, notEqual;

  int checks = 0;
  int errors = 0;

  logic a_stall, a_flush_ifid, a_ex_ALUsrc, a_ex_link, a_ex_regWrite, a_ex_memRead, a_ex_memWrite;
  logic a_mem_regWrite, a_mem_memRead, a_mem_memWrite, a_mem_memToReg, a_wb_regWrite, a_wb_memToReg, a_wb_nop;
  logic [1:0] a_PCsrc;
  logic [2:0] a_ex_ALUop;
  logic [4:0] a_ex_wreg, a_mem_wreg, a_wb_wreg;
  logic [15:0] a_stall_cnt, a_flush_cnt;

  logic b_stall, b_flush_ifid, b_ex_ALUsrc, b_ex_link, b_ex_regWrite, b_ex_memRead, b_ex_memWrite;
  logic b_mem_regWrite, b_mem_memRead, b_mem_memWrite, b_mem_memToReg, b_wb_regWrite, b_wb_memToReg, b_wb_nop;
  logic [1:0] b_PCsrc;
  logic [2:0] b_ex_ALUop;
  logic [4:0] b_ex_wreg, b_mem_wreg, b_wb_wreg;
  logic [15:0] b_stall_cnt, b_flush_cnt;

  logic c_stall, c_flush_ifid, c_ex_ALUsrc, c_ex_link, c_ex_regWrite, c_ex_memRead, c_ex_memWrite;
  logic c_mem_regWrite, c_mem_memRead, c_mem_memWrite, c_mem_memToReg, c_wb_regWrite, c_wb_memToReg, c_wb_nop;
  logic [1:0] c_PCsrc;
  logic [2:0] c_ex_ALUop;
  logic [4:0] c_ex_wreg, c_mem_wreg, c_wb_wreg;
  logic [1:0] c_stall_cnt, c_flush_cnt;

  cu_pipe u_a (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .rs(rs), .rt(rt), .rd(rd),
    .equal(equal), .notEqual(notEqual), .stall(a_stall), .flush_ifid(a_flush_ifid), .PCsrc(a_PCsrc),
    .ex_ALUop(a_ex_ALUop), .ex_ALUsrc(a_ex_ALUsrc), .ex_link(a_ex_link), .ex_wreg(a_ex_wreg),
    .ex_regWrite(a_ex_regWrite), .ex_memRead(a_ex_memRead), .ex_memWrite(a_ex_memWrite),
    .mem_wreg(a_mem_wreg), .mem_regWrite(a_mem_regWrite), .mem_memRead(a_mem_memRead),
    .mem_memWrite(a_mem_memWrite), .mem_memToReg(a_mem_memToReg), .wb_wreg(a_wb_wreg),
    .wb_regWrite(a_wb_regWrite), .wb_memToReg(a_wb_memToReg), .wb_nop(a_wb_nop),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  cu_pipe #(.EN_JAL(1'b0)) u_b (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .rs(rs), .rt(rt), .rd(rd),
    .equal(equal), .notEqual(notEqual), .stall(b_stall), .flush_ifid(b_flush_ifid), .PCsrc(b_PCsrc),
    .ex_ALUop(b_ex_ALUop), .ex_ALUsrc(b_ex_ALUsrc), .ex_link(b_ex_link), .ex_wreg(b_ex_wreg),
    .ex_regWrite(b_ex_regWrite), .ex_memRead(b_ex_memRead), .ex_memWrite(b_ex_memWrite),
    .mem_wreg(b_mem_wreg), .mem_regWrite(b_mem_regWrite), .mem_memRead(b_mem_memRead),
    .mem_memWrite(b_mem_memWrite), .mem_memToReg(b_mem_memToReg), .wb_wreg(b_wb_wreg),
    .wb_regWrite(b_wb_regWrite), .wb_memToReg(b_wb_memToReg), .wb_nop(b_wb_nop),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  cu_pipe #(.CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .rs(rs), .rt(rt), .rd(rd),
    .equal(equal), .notEqual(notEqual), .stall(c_stall), .flush_ifid(c_flush_ifid), .PCsrc(c_PCsrc),
    .ex_ALUop(c_ex_ALUop), .ex_ALUsrc(c_ex_ALUsrc), .ex_link(c_ex_link), .ex_wreg(c_ex_wreg),
    .ex_regWrite(c_ex_regWrite), .ex_memRead(c_ex_memRead), .ex_memWrite(c_ex_memWrite),
    .mem_wreg(c_mem_wreg), .mem_regWrite(c_mem_regWrite), .mem_memRead(c_mem_memRead),
    .mem_memWrite(c_mem_memWrite), .mem_memToReg(c_mem_memToReg), .wb_wreg(c_wb_wreg),
    .wb_regWrite(c_wb_regWrite), .wb_memToReg(c_wb_memToReg), .wb_nop(c_wb_nop),
    .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d, input logic eq, input logic ne);
    opcode = op; func = fn; rs = s; rt = t; rd = d; equal = eq; notEqual = ne;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_id(T_J, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    checks++; if (a_PCsrc !== 2'd0) begin errors++; $display("FAIL rst_pcsrc got=%0d exp=0", a_PCsrc); end
    checks++; if (a_flush_ifid !== 1'b0) begin errors++; $display("FAIL rst_flush got=%0b exp=0", a_flush_ifid); end
    rst = 1'b0;
    set_id(T_NOP, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    checks++; if (a_wb_nop !== 1'b1) begin errors++; $display("FAIL rst_wb_nop got=%0b exp=1", a_wb_nop); end
    checks++; if (a_ex_ALUop !== 3'b111) begin errors++; $display("FAIL rst_aluop got=%0b exp=111", a_ex_ALUop); end
    checks++; if (a_ex_wreg !== 5'd0) begin errors++; $display("FAIL rst_ex_wreg got=%0d exp=0", a_ex_wreg); end
    checks++; if (a_stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt got=%0d exp=0", a_stall_cnt); end
    checks++; if (a_flush_cnt !== 16'd0) begin errors++; $display("FAIL rst_flush_cnt got=%0d exp=0", a_flush_cnt); end
  endtask

  task automatic test_rtype();
    set_id(T_RTYPE, 6'd0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL rt_stall got=%0b exp=0", a_stall); end
    tick();
    checks++; if (a_ex_ALUop !== 3'b000) begin errors++; $display("FAIL rt_ex_aluop got=%0b exp=000", a_ex_ALUop); end
    checks++; if (a_ex_wreg !== 5'd3) begin errors++; $display("FAIL rt_ex_wreg got=%0d exp=3", a_ex_wreg); end
    set_id(T_NOP, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    checks++; if (a_mem_wreg !== 5'd3) begin errors++; $display("FAIL rt_mem_wreg got=%0d exp=3", a_mem_wreg); end
    tick();
    checks++; if (a_wb_regWrite !== 1'b1) begin errors++; $display("FAIL rt_wb_regwrite got=%0b exp=1", a_wb_regWrite); end
    checks++; if (a_wb_wreg !== 5'd3) begin errors++; $display("FAIL rt_wb_wreg got=%0d exp=3", a_wb_wreg); end
    checks++; if (a_wb_nop !== 1'b0) begin errors++; $display("FAIL rt_wb_nop got=%0b exp=0", a_wb_nop); end
  endtask

  task automatic test_load_use();
    set_id(T_LW, 6'd0, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);
    tick();
    set_id(T_RTYPE, 6'd0, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0);
    checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%0b exp=1", a_stall); end
    checks++; if (a_flush_ifid !== 1'b0) begin errors++; $display("FAIL lu_flush got=%0b exp=0", a_flush_ifid); end
    tick();
    checks++; if (a_ex_regWrite !== 1'b0) begin errors++; $display("FAIL lu_bubble_rw got=%0b exp=0", a_ex_regWrite); end
    checks++; if (a_ex_ALUop !== 3'b111) begin errors++; $display("FAIL lu_bubble_aluop got=%0b exp=111", a_ex_ALUop); end
    checks++; if (a_mem_memRead !== 1'b1) begin errors++; $display("FAIL lu_mem_memread got=%0b exp=1", a_mem_memRead); end
    checks++; if (a_stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", a_stall_cnt); end
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_release got=%0b exp=0", a_stall); end
    tick();
    checks++; if (a_ex_wreg !== 5'd6) begin errors++; $display("FAIL lu_ex_wreg got=%0d exp=6", a_ex_wreg); end
    checks++; if (a_stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt_hold got=%0d exp=1", a_stall_cnt); end
  endtask

  task automatic test_branch_hazard();
    set_id(T_LW, 6'd0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0);
    tick();
    set_id(T_BEQ, 6'd0, 5'd7, 5'd1, 5'd0, 1'b1, 1'b0);
    checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL br_stall1 got=%0b exp=1", a_stall); end
    checks++; if (a_PCsrc !== 2'd0) begin errors++; $display("FAIL br_pcsrc_hold got=%0d exp=0", a_PCsrc); end
    tick();
    checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL br_stall2 got=%0b exp=1", a_stall); end
    tick();
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL br_stall3 got=%0b exp=0", a_stall); end
    checks++; if (a_PCsrc !== 2'd1) begin errors++; $display("FAIL br_pcsrc got=%0d exp=1", a_PCsrc); end
    checks++; if (a_flush_ifid !== 1'b1) begin errors++; $display("FAIL br_flush got=%0b exp=1", a_flush_ifid); end
    tick();
    checks++; if (a_stall_cnt !== 16'd3) begin errors++; $display("FAIL br_stall_cnt got=%0d exp=3", a_stall_cnt); end
    checks++; if (a_flush_cnt !== 16'd1) begin errors++; $display("FAIL br_flush_cnt got=%0d exp=1", a_flush_cnt); end
  endtask

  task automatic test_jal();
    set_id(T_JAL, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    checks++; if (a_PCsrc !== 2'd2) begin errors++; $display("FAIL jal_pcsrc got=%0d exp=2", a_PCsrc); end
    checks++; if (a_flush_ifid !== 1'b1) begin errors++; $display("FAIL jal_flush got=%0b exp=1", a_flush_ifid); end
    checks++; if (b_PCsrc !== 2'd0) begin errors++; $display("FAIL nojal_pcsrc got=%0d exp=0", b_PCsrc); end
    checks++; if (b_flush_ifid !== 1'b0) begin errors++; $display("FAIL nojal_flush got=%0b exp=0", b_flush_ifid); end
    tick();
    checks++; if (a_ex_wreg !== 5'd31) begin errors++; $display("FAIL jal_ex_wreg got=%0d exp=31", a_ex_wreg); end
    checks++; if (a_ex_link !== 1'b1) begin errors++; $display("FAIL jal_ex_link got=%0b exp=1", a_ex_link); end
    checks++; if (a_ex_regWrite !== 1'b1) begin errors++; $display("FAIL jal_ex_rw got=%0b exp=1", a_ex_regWrite); end
    checks++; if (a_flush_cnt !== 16'd2) begin errors++; $display("FAIL jal_flush_cnt got=%0d exp=2", a_flush_cnt); end
    checks++; if (b_ex_link !== 1'b0) begin errors++; $display("FAIL nojal_ex_link got=%0b exp=0", b_ex_link); end
    checks++; if (b_ex_regWrite !== 1'b0) begin errors++; $display("FAIL nojal_ex_rw got=%0b exp=0", b_ex_regWrite); end
    checks++; if (b_ex_ALUop !== 3'b111) begin errors++; $display("FAIL nojal_ex_aluop got=%0b exp=111", b_ex_ALUop); end
  endtask

  task automatic test_bne();
    set_id(T_BNE, 6'd0, 5'd2, 5'd3, 5'd0, 1'b0, 1'b1);
    checks++; if (a_PCsrc !== 2'd1) begin errors++; $display("FAIL bne_taken_pcsrc got=%0d exp=1", a_PCsrc); end
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL bne_stall got=%0b exp=0", a_stall); end
    set_id(T_BNE, 6'd0, 5'd2, 5'd3, 5'd0, 1'b1, 1'b0);
    checks++; if (a_PCsrc !== 2'd0) begin errors++; $display("FAIL bne_nt_pcsrc got=%0d exp=0", a_PCsrc); end
    checks++; if (a_flush_ifid !== 1'b0) begin errors++; $display("FAIL bne_nt_flush got=%0b exp=0", a_flush_ifid); end
    set_id(T_NOP, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_decode_misc();
    set_id(T_ORI, 6'd0, 5'd1, 5'd9, 5'd0, 1'b0, 1'b0);
    tick();
    checks++; if (a_ex_ALUop !== 3'b011) begin errors++; $display("FAIL ori_aluop got=%0b exp=011", a_ex_ALUop); end
    checks++; if (a_ex_ALUsrc !== 1'b1) begin errors++; $display("FAIL ori_alusrc got=%0b exp=1", a_ex_ALUsrc); end
    checks++; if (a_ex_wreg !== 5'd9) begin errors++; $display("FAIL ori_wreg got=%0d exp=9", a_ex_wreg); end
    set_id(T_RTYPE, 6'd5, 5'd1, 5'd2, 5'd4, 1'b0, 1'b0);
    tick();
    checks++; if (a_ex_ALUop !== 3'b111) begin errors++; $display("FAIL badfn_aluop got=%0b exp=111", a_ex_ALUop); end
    checks++; if (a_ex_regWrite !== 1'b0) begin errors++; $display("FAIL badfn_rw got=%0b exp=0", a_ex_regWrite); end
    set_id(T_SW, 6'd0, 5'd1, 5'd4, 5'd0, 1'b0, 1'b0);
    tick();
    checks++; if (a_ex_memWrite !== 1'b1) begin errors++; $display("FAIL sw_memwrite got=%0b exp=1", a_ex_memWrite); end
    checks++; if (a_ex_ALUop !== 3'b000) begin errors++; $display("FAIL sw_aluop got=%0b exp=000", a_ex_ALUop); end
    checks++; if (a_ex_regWrite !== 1'b0) begin errors++; $display("FAIL sw_rw got=%0b exp=0", a_ex_regWrite); end
  endtask

  task automatic test_zero_reg();
    set_id(T_LW, 6'd0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    set_id(T_RTYPE, 6'd0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0);
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL r0_lu_stall got=%0b exp=0", a_stall); end
    set_id(T_BEQ, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL r0_br_stall got=%0b exp=0", a_stall); end
    set_id(T_NOP, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_stall();
    set_id(T_LW, 6'd0, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);
    tick();
    set_id(T_RTYPE, 6'd0, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0);
    checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall got=%0b exp=1", a_stall); end
    rst = 1'b1;
    #1;
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL mid_rst_stall got=%0b exp=0", a_stall); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (a_mem_memRead !== 1'b0) begin errors++; $display("FAIL mid_mem_memread got=%0b exp=0", a_mem_memRead); end
    checks++; if (a_ex_memRead !== 1'b0) begin errors++; $display("FAIL mid_ex_memread got=%0b exp=0", a_ex_memRead); end
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL mid_post_stall got=%0b exp=0", a_stall); end
    checks++; if (a_stall_cnt !== 16'd0) begin errors++; $display("FAIL mid_stall_cnt got=%0d exp=0", a_stall_cnt); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      set_id(T_LW, 6'd0, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);
      tick();
      set_id(T_RTYPE, 6'd0, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0);
      checks++; if (c_stall !== 1'b1) begin errors++; $display("FAIL sat_stall[%0d] got=%0b exp=1", i, c_stall); end
      tick();
    end
    checks++; if (c_stall_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt got=%0d exp=3", c_stall_cnt); end
    checks++; if (a_stall_cnt !== 16'd5) begin errors++; $display("FAIL wide_cnt got=%0d exp=5", a_stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_use();
    test_branch_hazard();
    test_jal();
    test_bne();
    test_decode_misc();
    test_zero_reg();
    test_reset_mid_stall();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
